// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data memory target with fixed access latency
// One request in flight; the access itself happens on the edge that enters RESP.
module data_mem_responder #(
    parameter int DEPTH_DW = 256,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         IDX_W    = $clog2(DEPTH_DW);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0]      mem [DEPTH_DW];
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             resp_entry;
    logic             mem_we;

    // Upper address bits only participate in the range check, never in indexing.
    assign idx        = addr_q[IDX_W+2:3];
    assign acc_err    = (|addr_q[2:0]) | (|addr_q[63:IDX_W+3]);
    assign resp_entry = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we     = rst && resp_entry && we_q && !acc_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = acc_err;
                    rdata_d = (!we_q && !acc_err) ? mem[idx] : 64'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed checks of data_mem_responder at LATENCY 2 and 1
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    logic [1:0]  rdy;
    logic [1:0]  vld;
    logic [1:0]  er;
    logic [63:0] rd [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_DW(256), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0])
    );

    data_mem_responder #(.DEPTH_DW(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Full request/response; returns data, error flag and edges from accept to rsp_valid.
    task automatic xact(input int sel, input logic we, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rdata, output logic err, output int lat);
        @(negedge clk);
        check("req_ready_idle", 64'(rdy[sel]), 64'd1);
        req_we         = we;
        req_addr       = a;
        req_wdata      = d;
        req_valid[sel] = 1'b1;
        @(posedge clk);
        #1 req_valid[sel] = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 lat++;
            if (vld[sel]) break;
        end
        if (!vld[sel]) check("rsp_timeout", 64'(vld[sel]), 64'd1);
        rdata     = rd[sel];
        err       = er[sel];
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    logic [63:0] r;
    logic        e;
    int          l;

    initial begin
        rst = 1'b0; req_valid = 2'b00; req_we = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(rdy[0]), 64'd1);
        check("rst_rsp_valid", 64'(vld[0]), 64'd0);
        check("rst_rsp_rdata", rd[0], 64'd0);
        check("rst_rsp_err", 64'(er[0]), 64'd0);
        check("rst_l1_ready", 64'(rdy[1]), 64'd1);
        rst = 1'b1;

        // Store then load at 0x10
        xact(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, r, e, l);
        check("st10_lat", 64'(l), 64'd2);
        check("st10_rdata", r, 64'd0);
        check("st10_err", 64'(e), 64'd0);
        xact(0, 1'b0, 64'h10, 64'd0, r, e, l);
        check("ld10_lat", 64'(l), 64'd2);
        check("ld10_rdata", r, 64'hDEADBEEF_CAFEF00D);
        check("ld10_err", 64'(e), 64'd0);

        // Misaligned and out-of-range accesses
        xact(0, 1'b0, 64'h13, 64'd0, r, e, l);
        check("ld13_err", 64'(e), 64'd1);
        check("ld13_rdata", r, 64'd0);
        xact(0, 1'b0, 64'h800, 64'd0, r, e, l);
        check("ld800_err", 64'(e), 64'd1);
        check("ld800_rdata", r, 64'd0);
        xact(0, 1'b1, 64'h13, 64'h1111, r, e, l);
        check("st13_err", 64'(e), 64'd1);
        xact(0, 1'b1, 64'h810, 64'h2222, r, e, l);
        check("st810_err", 64'(e), 64'd1);
        xact(0, 1'b1, 64'h8000_0000_0000_0010, 64'h3333, r, e, l);
        check("sthi_err", 64'(e), 64'd1);
        xact(0, 1'b0, 64'h10, 64'd0, r, e, l);
        check("idx2_intact", r, 64'hDEADBEEF_CAFEF00D);

        // Response backpressure
        @(negedge clk);
        req_we = 1'b0; req_addr = 64'h10; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        for (int i = 0; i < 20 && !vld[0]; i++) @(negedge clk);
        check("bp_valid_rise", 64'(vld[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(vld[0]), 64'd1);
            check("bp_rdata", rd[0], 64'hDEADBEEF_CAFEF00D);
            check("bp_req_ready", 64'(rdy[0]), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp_rel_valid", 64'(vld[0]), 64'd0);
        check("bp_rel_ready", 64'(rdy[0]), 64'd1);
        check("bp_rel_rdata", rd[0], 64'd0);
        check("bp_rel_err", 64'(er[0]), 64'd0);

        // Reset during WAIT abandons the store
        xact(0, 1'b1, 64'h8, 64'h5555, r, e, l);
        check("st8_err", 64'(e), 64'd0);
        @(negedge clk);
        req_we = 1'b1; req_addr = 64'h8; req_wdata = 64'h1234; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("wait_ready", 64'(rdy[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_ready", 64'(rdy[0]), 64'd1);
        check("midrst_valid", 64'(vld[0]), 64'd0);
        @(negedge clk);
        check("midrst_valid2", 64'(vld[0]), 64'd0);
        xact(0, 1'b0, 64'h8, 64'd0, r, e, l);
        check("ld8_old", r, 64'h5555);

        // LATENCY=1 instance, in-order back-to-back loads
        xact(1, 1'b1, 64'h0, 64'hA0A0_0000_0000_00A0, r, e, l);
        check("l1_st0_lat", 64'(l), 64'd1);
        xact(1, 1'b1, 64'h8, 64'hB1B1_0000_0000_00B1, r, e, l);
        check("l1_st8_err", 64'(e), 64'd0);
        xact(1, 1'b0, 64'h0, 64'd0, r, e, l);
        check("l1_ld0_lat", 64'(l), 64'd1);
        check("l1_ld0_rdata", r, 64'hA0A0_0000_0000_00A0);
        xact(1, 1'b0, 64'h8, 64'd0, r, e, l);
        check("l1_ld8_rdata", r, 64'hB1B1_0000_0000_00B1);
        check("l1_ld8_err", 64'(e), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
